puf_race_launcher: RTL

Host-side driver for the arbiter-PUF race arbiter. It takes a challenge seed from the host and expands it through an LFSR into one challenge per response bit. For each bit it drives the challenge onto the delay chains, fires the race launch edge, waits for the arbiter's `done`, and captures its winner bit. It then resets the arbiter and delivers the packed response word to the host on completion.

---
 rtl/puf_race_launcher.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/puf_race_launcher.sv
// Arbiter-PUF race launcher: expands a seed through an LFSR, runs one race per response bit and
// packs the winner bits. Optional macro PUF_MAJORITY_VOTE_EN: three races per bit, majority kept.
module puf_race_launcher #(
  parameter int unsigned       CHAL_W      = 64,
  parameter int unsigned       NUM_RESP    = 32,
  parameter logic [CHAL_W-1:0] TAPS        = 64'hD800_0000_0000_0000,
  parameter int unsigned       SETTLE_CYC  = 4,
  parameter int unsigned       TIMEOUT_CYC = 255,
  parameter int unsigned       RESET_CYC   = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [CHAL_W-1:0]   i_seed,
  output logic                o_busy,
  output logic [CHAL_W-1:0]   o_challenge,
  output logic                o_launch,
  output logic                o_arb_reset,
  input  logic                i_arb_done,
  input  logic                i_arb_out,
  output logic [NUM_RESP-1:0] o_resp,
  output logic                o_resp_valid,
  output logic                o_timeout_err
);

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int unsigned RACES = 3;
`else
  localparam int unsigned RACES = 1;
`endif
  localparam int unsigned THRESH  = RACES / 2 + 1;
  localparam int unsigned IDX_W   = (NUM_RESP > 1) ? $clog2(NUM_RESP) : 1;
  localparam int unsigned MAX_SR  = (SETTLE_CYC > RESET_CYC) ? SETTLE_CYC : RESET_CYC;
  localparam int unsigned CNT_MAX = (TIMEOUT_CYC > MAX_SR) ? TIMEOUT_CYC : MAX_SR;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StFire,
    StCapture,
    StRecover,
    StDone
  } state_t;

  state_t              r_state;
  logic                r_done_meta, r_done_s;
  logic                r_out_meta, r_out_s;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [1:0]          r_race;
  logic [1:0]          r_votes;
  logic [CHAL_W-1:0]   r_lfsr;
  logic                r_busy;
  logic                r_launch;
  logic                r_arb_reset;
  logic [NUM_RESP-1:0] r_resp;
  logic                r_resp_valid;
  logic                r_tout;

  logic [CHAL_W-1:0]   w_lfsr_next;
  logic [CHAL_W-1:0]   w_seed;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_last_race;
  logic                w_last_idx;
  logic                w_vote_cap;
  logic                w_vote_to;
  logic                w_settle_done;
  logic                w_fire_to;
  logic                w_recover_ok;

  assign w_lfsr_next   = {r_lfsr[CHAL_W-2:0], ^(r_lfsr & TAPS)};
  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  assign w_seed        = (i_seed == '0) ? {{(CHAL_W-1){1'b0}}, 1'b1} : i_seed;
  assign w_cnt_inc     = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  assign w_last_race   = (r_race == 2'(RACES - 1));
  assign w_last_idx    = (r_idx == IDX_W'(NUM_RESP - 1));
  assign w_vote_cap    = ({1'b0, r_votes} + {2'b00, r_out_s}) >= 3'(THRESH);
  assign w_vote_to     = {1'b0, r_votes} >= 3'(THRESH);
  assign w_settle_done = (r_cnt == CNT_W'(SETTLE_CYC - 1));
  assign w_fire_to     = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_recover_ok  = (r_cnt >= CNT_W'(RESET_CYC - 1)) && !r_done_s;

  // Arbiter outputs are asynchronous to i_clk.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_done_meta <= 1'b0;
      r_done_s    <= 1'b0;
      r_out_meta  <= 1'b0;
      r_out_s     <= 1'b0;
    end else begin
      r_done_meta <= i_arb_done;
      r_done_s    <= r_done_meta;
      r_out_meta  <= i_arb_out;
      r_out_s     <= r_out_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_race       <= '0;
      r_votes      <= '0;
      r_lfsr       <= '0;
      r_busy       <= 1'b0;
      r_launch     <= 1'b0;
      r_arb_reset  <= 1'b1;
      r_resp       <= '0;
      r_resp_valid <= 1'b0;
      r_tout       <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_cnt        <= w_cnt_inc;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_lfsr      <= w_seed;
            r_idx       <= '0;
            r_race      <= '0;
            r_votes     <= '0;
            r_resp      <= '0;
            r_tout      <= 1'b0;
            r_busy      <= 1'b1;
            r_arb_reset <= 1'b0;
            r_cnt       <= '0;
            r_state     <= StSettle;
          end
        end
        StSettle: begin
          if (w_settle_done) begin
            r_launch <= 1'b1;
            r_cnt    <= '0;
            r_state  <= StFire;
          end
        end
        StFire: begin
          if (r_done_s) begin
            r_state <= StCapture;
          end else if (w_fire_to) begin
            // A timed-out race contributes a 0 vote.
            if (w_last_race) r_resp[r_idx] <= w_vote_to;
            r_tout      <= 1'b1;
            r_launch    <= 1'b0;
            r_arb_reset <= 1'b1;
            r_cnt       <= '0;
            r_state     <= StRecover;
          end
        end
        StCapture: begin
          if (w_last_race) r_resp[r_idx] <= w_vote_cap;
          else             r_votes <= r_votes + {1'b0, r_out_s};
          r_launch    <= 1'b0;
          r_arb_reset <= 1'b1;
          r_cnt       <= '0;
          r_state     <= StRecover;
        end
        StRecover: begin
          if (w_recover_ok) begin
            if (!w_last_race) begin
              r_race      <= r_race + 2'd1;
              r_arb_reset <= 1'b0;
              r_cnt       <= '0;
              r_state     <= StSettle;
            end else if (w_last_idx) begin
              r_resp_valid <= 1'b1;
              r_state      <= StDone;
            end else begin
              r_idx       <= r_idx + 1'b1;
              r_race      <= '0;
              r_votes     <= '0;
              r_lfsr      <= w_lfsr_next;
              r_arb_reset <= 1'b0;
              r_cnt       <= '0;
              r_state     <= StSettle;
            end
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_challenge   = r_lfsr;
  assign o_launch      = r_launch;
  assign o_arb_reset   = r_arb_reset;
  assign o_resp        = r_resp;
  assign o_resp_valid  = r_resp_valid;
  assign o_timeout_err = r_tout;

endmodule
